// File: rtl/pulse_pkg.sv
// Shared symbol codes and classifier state encoding for the keylock pulse path.
package pulse_pkg;

  localparam logic [1:0] SYM_SHORT = 2'b00;
  localparam logic [1:0] SYM_LONG  = 2'b01;
  localparam logic [1:0] SYM_ERR   = 2'b10;
  localparam logic [1:0] SYM_END   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HIGH = ST_HIGH,
    HOLD = ST_HOLD,
    LOW  = ST_LOW
  } state_t;

endpackage

// File: rtl/sync_deglitch.sv
// Multi-flop input synchroniser with optional 2-cycle stability filter.
// Filter is built when DEGLITCH_EN is defined.
module sync_deglitch #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic din_s
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

`ifdef DEGLITCH_EN
  logic prev_q;
  logic filt_q;

  // Output follows only once two consecutive samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      prev_q <= sync_q[STAGES-1];
      if (sync_q[STAGES-1] == prev_q) begin
        filt_q <= prev_q;
      end
    end
  end

  assign din_s = filt_q;
`else
  assign din_s = sync_q[STAGES-1];
`endif

endmodule

// File: rtl/pulse_symbol_classifier.sv
// Classifies DIN high pulses as SHORT/LONG/ERROR, detects END gaps.
// Optional input deglitch filter: define DEGLITCH_EN.
module pulse_symbol_classifier
  import pulse_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SHORT_MAX   = 3,
  parameter int LONG_MAX    = 8,
  parameter int GAP_MIN     = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       DIN,
  input  logic       SYM_READY,
  output logic       SYM_VALID,
  output logic [1:0] SYM,
  output logic       DOUT_SHORT,
  output logic       DOUT_LONG,
  output logic       OVERFLOW
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_MAX);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_MIN);

  logic din_s;

  sync_deglitch #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (DIN),
    .din_s(din_s)
  );

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             emit;
  logic [1:0]       emit_sym;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_sym = SYM_SHORT;
    unique case (state_q)
      IDLE: begin
        if (din_s) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        if (din_s) begin
          // One more high cycle would pass LONG_MAX.
          if (cnt_q >= LONG_C) begin
            emit     = 1'b1;
            emit_sym = SYM_ERR;
            state_d  = HOLD;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          emit     = 1'b1;
          emit_sym = (cnt_q <= SHORT_C) ? SYM_SHORT : SYM_LONG;
          state_d  = LOW;
          cnt_d    = CNT_ONE;
        end
      end
      HOLD: begin
        if (!din_s) begin
          state_d = LOW;
          cnt_d   = CNT_ONE;
        end
      end
      LOW: begin
        if (din_s) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end else if (cnt_inc >= GAP_C) begin
          emit     = 1'b1;
          emit_sym = SYM_END;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // One-entry output register; strobes ignore backpressure.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      SYM_VALID  <= 1'b0;
      SYM        <= SYM_SHORT;
      DOUT_SHORT <= 1'b0;
      DOUT_LONG  <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      DOUT_SHORT <= emit && (emit_sym == SYM_SHORT);
      DOUT_LONG  <= emit && (emit_sym == SYM_LONG);
      if (emit) begin
        if (!SYM_VALID || SYM_READY) begin
          SYM_VALID <= 1'b1;
          SYM       <= emit_sym;
        end else begin
          OVERFLOW <= 1'b1;
        end
      end else if (SYM_READY) begin
        SYM_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_symbol_classifier.sv
// Directed + random bench for pulse_symbol_classifier with run-length model.
module tb_pulse_symbol_classifier;

  localparam int N         = 3000;
  localparam int SHORT_MAX = 3;
  localparam int LONG_MAX  = 8;
  localparam int GAP_MIN   = 6;
  localparam int SYNC      = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       DIN = 1'b0;
  logic       SYM_READY = 1'b1;
  logic       SYM_VALID;
  logic [1:0] SYM;
  logic       DOUT_SHORT;
  logic       DOUT_LONG;
  logic       OVERFLOW;

  pulse_symbol_classifier #(
    .CNT_W      (8),
    .SHORT_MAX  (SHORT_MAX),
    .LONG_MAX   (LONG_MAX),
    .GAP_MIN    (GAP_MIN),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .DIN       (DIN),
    .SYM_READY (SYM_READY),
    .SYM_VALID (SYM_VALID),
    .SYM       (SYM),
    .DOUT_SHORT(DOUT_SHORT),
    .DOUT_LONG (DOUT_LONG),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // d[j]/r[j]: DIN and SYM_READY as sampled by clock edge j.
  bit       d [0:N];
  bit       r [0:N];
  bit       ds[0:N];
  bit       em[0:N];
  bit [1:0] es[0:N];
  int       n = 0;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic add(input int hi, input int lo, input int rd);
    for (int i = 0; i < hi + lo; i++) begin
      n++;
      d[n] = (i < hi);
      r[n] = (rd == 2) ? ($urandom_range(0, 3) != 0) : rd[0];
    end
  endtask

  function automatic bit raw_s(input int j);
    return (j - SYNC >= 0) ? d[j - SYNC] : 1'b0;
  endfunction

  task automatic mark(input int j, input bit [1:0] s);
    if (j <= n) begin
      em[j] = 1'b1;
      es[j] = s;
    end
  endtask

  task automatic build_model();
    int j;
    int a;
    int c;
`ifdef DEGLITCH_EN
    bit f [0:N];
    f[0] = 1'b0;
    for (int k = 1; k <= n; k++)
      f[k] = (raw_s(k-1) == raw_s(k-2)) ? raw_s(k-1) : f[k-1];
    for (int k = 1; k <= n; k++) ds[k] = f[k];
`else
    for (int k = 1; k <= n; k++) ds[k] = raw_s(k);
`endif
    j = 1;
    while (j <= n) begin
      if (ds[j]) begin
        a = j;
        while (j <= n && ds[j]) j++;
        if (j - a > LONG_MAX) mark(a + LONG_MAX, 2'b10);
        else if (j - a <= SHORT_MAX) mark(j, 2'b00);
        else mark(j, 2'b01);
        c = j;
        while (j <= n && !ds[j]) j++;
        if (j - c >= GAP_MIN) mark(c + GAP_MIN - 1, 2'b11);
      end else begin
        j++;
      end
    end
  endtask

  bit       mv;
  bit [1:0] ms;
  bit       mo;
  bit       msh;
  bit       mlg;

  initial begin
    add(2, 10, 1);
    add(3, 10, 1);
    add(4, 10, 1);
    add(8, 10, 1);
    add(12, 10, 1);
    add(2, 2, 0);
    add(2, 4, 0);
    add(0, 10, 1);
    add(2, 5, 1);
    add(2, 6, 1);
    add(2, 10, 1);
    add(1, 10, 1);
    for (int p = 0; p < 40; p++)
      add($urandom_range(1, 12), $urandom_range(1, 10), 2);
    add(0, 12, 1);
    build_model();

    repeat (3) @(posedge CLK);
    #1;
    chk("reset", {3'b0, SYM_VALID, SYM, DOUT_SHORT, DOUT_LONG}, 8'h00);
    chk("reset_ovf", {7'b0, OVERFLOW}, 8'h00);

    mv = 0; ms = 0; mo = 0;
    for (int j = 1; j <= n; j++) begin
      @(negedge CLK);
      RST_N     = 1'b1;
      DIN       = d[j];
      SYM_READY = r[j];
      @(posedge CLK);
      #1;
      msh = em[j] && es[j] == 2'b00;
      mlg = em[j] && es[j] == 2'b01;
      if (em[j]) begin
        if (!mv || r[j]) begin
          mv = 1;
          ms = es[j];
        end else begin
          mo = 1;
        end
      end else if (r[j]) begin
        mv = 0;
      end
      chk($sformatf("cyc%0d", j),
          {2'b0, SYM_VALID, mv ? SYM : 2'b00, DOUT_SHORT, DOUT_LONG, OVERFLOW},
          {2'b0, mv, mv ? ms : 2'b00, msh, mlg, mo});
    end

    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      DIN       = 1'b1;
      SYM_READY = 1'b1;
    end
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst",
        {3'b0, SYM_VALID, SYM, DOUT_SHORT, DOUT_LONG} | {7'b0, OVERFLOW},
        8'h00);
    @(negedge CLK);
    DIN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("post_rst%0d", k),
          {3'b0, SYM_VALID, DOUT_SHORT, DOUT_LONG, OVERFLOW, 1'b0}, 8'h00);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pulse_symbol_classifier.md
Name: pulse_symbol_classifier

Overview:
- Parametrised successor to the keylock short/long pulse detector.
- Measures the width of each high pulse on serial input DIN and classifies it as SHORT, LONG or ERROR.
- Detects the inter-group gap (END) and delivers symbols through a one-entry valid/ready output register. Legacy one-cycle strobes are kept alongside.
- Sits between the keypad/button input and the keylock sequence-compare FSM.

Parameters:
- CNT_W, 8: width of the pulse/gap counter; counter saturates at 2^CNT_W-1.
- SHORT_MAX, 3: longest high pulse, in cycles, classified SHORT.
- LONG_MAX, 8: longest high pulse classified LONG; must be > SHORT_MAX and < 2^CNT_W-1.
- GAP_MIN, 6: consecutive low cycles after a pulse that produce END; must be < 2^CNT_W-1.
- SYNC_STAGES, 2: flip-flops in the DIN synchroniser; minimum 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- DIN  in  1  raw serial pulse input, asynchronous to CLK.
- SYM_READY  in  1  consumer accepts SYM this cycle.
- SYM_VALID  out  1  SYM holds an unconsumed symbol.
- SYM  out  2  symbol code: 00 SHORT, 01 LONG, 10 ERROR, 11 END.
- DOUT_SHORT  out  1  one-cycle strobe when a SHORT is classified.
- DOUT_LONG  out  1  one-cycle strobe when a LONG is classified.
- OVERFLOW  out  1  sticky; a symbol was dropped.

Behaviour:
Reset
- All outputs are 0, state is IDLE, counter is 0 and synchroniser flops are 0.
- Reset takes effect immediately (async) and releases synchronously on CLK.
- If DIN is high when reset releases, a rising edge is seen and the pulse is counted normally.

Input and states
- din_s is DIN after SYNC_STAGES flops. All measurement uses din_s.
- IDLE: wait for din_s=1. On din_s=1, go to HIGH with cnt=1.
- HIGH: cnt increments each cycle din_s=1 (saturating).
  - If cnt would exceed LONG_MAX while high: emit ERROR once and go to HOLD.
  - On din_s=0: classify cnt (1..SHORT_MAX gives SHORT; SHORT_MAX+1..LONG_MAX gives LONG), emit it, go to LOW with cnt=1.
- HOLD: ignore the remaining high time. On din_s=0, go to LOW with cnt=1; nothing is emitted at the fall.
- LOW: cnt increments while din_s=0.
  - When cnt reaches GAP_MIN: emit END and go to IDLE.
  - On din_s=1 before that: go to HIGH with cnt=1 and no END.

Emit and output handshake
- On an emit, SYM/SYM_VALID load at that clock edge and are visible the next cycle.
- Latency from a DIN fall at the pin to SYM_VALID is SYNC_STAGES+1 cycles.
- DOUT_SHORT and DOUT_LONG pulse high for exactly one cycle, coincident with the first cycle SYM_VALID shows that symbol.
- The strobes fire regardless of SYM_READY or overflow.
- Handshake: a transfer occurs when SYM_VALID and SYM_READY are both 1 on a clock edge. SYM_VALID then drops unless a new emit occurs on the same edge, in which case the new symbol loads and there is no bubble.
- SYM is held stable while SYM_VALID=1 and SYM_READY=0.
- Emit while SYM_VALID=1 and SYM_READY=0: the new symbol is dropped and OVERFLOW is set. OVERFLOW clears only on reset.
- The strobe still fires for a dropped SHORT/LONG.

Optional Feature:
- Macro DEGLITCH_EN.
- When defined, a stability filter follows the synchroniser: din_s changes only after the synchronised input has held a new value for 2 consecutive cycles.
  - Single-cycle glitches are removed.
  - Latency grows by 2 cycles.
  - Measured widths are otherwise unchanged.
- When undefined, din_s is the raw synchroniser output.

Decomposition:
- Shared package pulse_pkg holds:
  - the SYM code constants (SYM_SHORT=2'b00, SYM_LONG=2'b01, SYM_ERR=2'b10, SYM_END=2'b11);
  - the state encoding localparams (IDLE, HIGH, HOLD, LOW).
- One sub-module, sync_deglitch: the SYNC_STAGES synchroniser plus the DEGLITCH_EN filter. It is reusable for other keylock inputs.
- The classifier FSM, counter and output register stay in the top module.

Test Plan (defaults, SYM_READY=1 unless stated):
1. DIN high 2 cycles, then low 10 -> SYM=00 with DOUT_SHORT for 1 cycle, then SYM=11 six din_s-low cycles after the fall; DIN fall to SYM_VALID = 3 cycles.
2. Boundaries: high for 3, 4 and 8 cycles, each separated by a 10-cycle gap -> 00, 01, 01 (each followed by 11); DOUT_LONG pulses twice.
3. High 12 cycles -> SYM=10 exactly once, on the edge of the 9th high cycle; no symbol at the fall; END 6 cycles after the fall.
4. SYM_READY=0, two 2-cycle pulses with a 2-cycle gap -> first SHORT held stable, second dropped, OVERFLOW=1, two DOUT_SHORT strobes; SYM_READY=1 -> one transfer, then END; OVERFLOW stays 1.
5. Gap of 5 low cycles between pulses -> no END between them; gap of 6 -> END emitted.
6. RST_N low mid-pulse (cycle 5 of high) -> all outputs 0 asynchronously, no symbol after release; with DEGLITCH_EN, a 1-cycle DIN high glitch -> no symbol.
